qracc_layer_sequencer: RTL and testbench
========================================

// Module: qracc_layer_sequencer
// PURPOSE
//  Bus master that drives one accelerator layer per descriptor through the QrAcc CSR slave.
//  Sequence: accept descriptor -> write CSR regs 1..6 -> write MAIN with trigger -> poll MAIN busy -> signal done.
//  Sits between the host-side descriptor queue and the CSR bus, so the host does not hand-sequence layers.
// PARAMETERS
//  CSR_BASE_ADDR  32'h0000_0010  base of CSR window; reg n is at CSR_BASE_ADDR + n
//  POLL_GAP       4              idle cycles after trigger and between polls (>=1)
//  TIMEOUT_POLLS  16'hFFFF       max polls seeing busy=1 before error
// PORTS
//  clk                    in   1        clock
//  nrst                   in   1        synchronous active-low reset
//  desc_valid_i           in   1        descriptor valid
//  desc_ready_o           out  1        descriptor accepted when valid&&ready
//  desc_cfg_i             in   192      {PADDING,OFFSETS,CHANNELS,OFMAP,IFMAP,CONFIG}; [31:0]=CONFIG (reg1)
//  desc_trigger_i         in   3        qracc_trigger_t code written to MAIN[2:0]
//  desc_preserve_ifmap_i  in   1        written to MAIN[12]
//  abort_i                in   1        abandon current layer
//  bus_req_o              out  bus_req_t   addr/data_in/wen/valid to CSR slave
//  bus_resp_i             in   bus_resp_t  ready/data_out/rd_data_valid from CSR slave
//  busy_o                 out  1        high in any state except IDLE
//  done_o                 out  1        1-cycle pulse: layer finished OK
//  error_o                out  1        sticky timeout flag, cleared by next accepted descriptor or reset
//  layers_done_o          out  16       count of OK layers, wraps at 2^16
// BEHAVIOUR
//  Reset (nrst=0 at posedge): state IDLE, bus_req_o all-zero, done_o=0, error_o=0, layers_done_o=0, idx=0.
//  Bus rules:
//   - valid is held with addr/data/wen stable until the cycle it is sampled with ready=1.
//   - Write completes on that cycle.
//   - Read data is taken only on the later cycle bus_resp_i.rd_data_valid=1; data_out is ignored otherwise.
//   - Exactly one outstanding transaction at a time.
//  FSM:
//   IDLE     desc_ready_o=1. On valid:
//            - latch desc fields into registers
//            - clear error_o
//            - idx=1, go WR_CFG
//   WR_CFG   write reg idx, data=desc_cfg[32*(idx-1)+:32].
//            - On accept: idx==6 -> TRIGGER; else idx++.
//   TRIGGER  write reg 0, data={19'b0,preserve,8'b0,1'b0(clear),trigger}.
//            - On accept: gap counter=POLL_GAP, poll counter=0, go GAP.
//   GAP      count down; at 0 -> POLL_REQ.
//   POLL_REQ read reg 0. On accept -> POLL_WAIT.
//   POLL_WAIT on rd_data_valid:
//            - data[4]==0 (not busy) -> DONE.
//            - data[4]==1 and polls==TIMEOUT_POLLS-1 -> ERR.
//            - else polls++, reload gap, GAP.
//   DONE     done_o=1 for this cycle, layers_done_o++, -> IDLE. Descriptor is not accepted in DONE.
//   ERR      error_o=1. Issue clear write (reg 0, data bit3=1) -> IDLE.
//   ABORT    write reg 0 data=32'h8 (clear) -> IDLE. No done_o; error_o unchanged.
//  Abort:
//   - abort_i in any non-IDLE state goes to ABORT.
//   - If a write or read handshake is in flight, it is first completed; a read response is dropped.
//   - abort_i in IDLE is ignored.
//   - abort_i and desc_valid_i together in IDLE: the descriptor is accepted.
//  Latency:
//   - desc accept -> first bus valid: 1 cycle.
//   - 7 writes at ready=1: 7 cycles.
//   - done_o asserts 1 cycle after the poll response with busy=0.
//  MAIN bit5 (inst_write_mode) is always 0 from this block.
//  The internal_state field [11:8] is ignored.
// TESTING
//  - Reset mid-WR_CFG (idx=3) -> next cycle: bus valid=0, IDLE, desc_ready_o=1, counters 0.
//  - Descriptor CONFIG=32'h1133_2201, trigger=3'd1, busy clears after 2 polls:
//    -> writes 0x11..0x16 in order, then 0x10 with data 0x1, 2 reads of 0x10, done_o pulses once, layers_done_o=1.
//  - Slave ready held low 5 cycles on reg 3 write -> addr/data stable for all 6 cycles, no skipped or duplicated write.
//  - TIMEOUT_POLLS=3 with busy stuck 1:
//    -> exactly 3 reads, error_o=1, clear write data 0x8, back to IDLE.
//    -> next descriptor clears error_o.
//  - abort_i during GAP -> clear write to 0x10, IDLE, no done_o.
//  - abort_i during POLL_WAIT -> read response consumed and discarded, then clear write.
//  - Back-to-back descriptors with desc_valid_i held -> second accepted in IDLE after DONE; 7 writes repeat.

Source files
------------

// File: rtl/qracc_layer_sequencer.sv
`timescale 1ns/1ps
// Sequences one QrAcc layer per descriptor: six CSR config writes, a MAIN trigger write, busy polling, done/error report.
// Latency: first CSR request 1 cycle after descriptor accept; done_o 1 cycle after the not-busy poll response.
// Backpressure: each bus request is held stable until sampled with ready; descriptors are only accepted while idle.
// Bus packing: bus_req_o = {addr[31:0], data_in[31:0], wen, valid}; bus_resp_i = {ready, data_out[31:0], rd_data_valid}.
module qracc_layer_sequencer #(
    parameter logic [31:0] CSR_BASE_ADDR = 32'h0000_0010,
    parameter int unsigned POLL_GAP      = 4,
    parameter logic [15:0] TIMEOUT_POLLS = 16'hFFFF
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         desc_valid_i,
    output logic         desc_ready_o,
    input  logic [191:0] desc_cfg_i,
    input  logic [2:0]   desc_trigger_i,
    input  logic         desc_preserve_ifmap_i,
    input  logic         abort_i,
    output logic [65:0]  bus_req_o,
    input  logic [33:0]  bus_resp_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         error_o,
    output logic [15:0]  layers_done_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CFG, S_TRIGGER, S_GAP, S_POLL_REQ, S_POLL_WAIT, S_DONE, S_ERR, S_ABORT
    } state_t;

    // MAIN register: read request and the clear-command write (bit 3)
    localparam logic [65:0] RD_REQ    = {CSR_BASE_ADDR, 32'h0000_0000, 1'b0, 1'b1};
    localparam logic [65:0] CLEAR_REQ = {CSR_BASE_ADDR, 32'h0000_0008, 1'b1, 1'b1};

    state_t        state;
    logic [65:0]   req_q;
    logic [191:0]  cfg_q;
    logic [2:0]    trig_q;
    logic          pres_q;
    logic [2:0]    idx;
    logic [7:0]    gap_cnt;
    logic [15:0]   polls;
    logic          abort_pend;

    logic bus_ready;
    logic rd_vld;
    logic rd_busy;
    logic accept;
    logic abort_now;
    logic unused_resp;

    assign bus_ready   = bus_resp_i[33];
    assign rd_vld      = bus_resp_i[0];
    assign rd_busy     = bus_resp_i[5];    // MAIN busy bit; internal_state and the rest are don't-care
    assign unused_resp = ^{bus_resp_i[32:6], bus_resp_i[4:1]};

    assign accept       = req_q[0] & bus_ready;
    // an abort seen while a handshake is still open is remembered until that handshake closes
    assign abort_now    = abort_i | abort_pend;
    assign bus_req_o    = req_q;
    assign desc_ready_o = (state == S_IDLE);
    assign busy_o       = (state != S_IDLE);

    function automatic logic [65:0] wr_req(input logic [31:0] off, input logic [31:0] dat);
        return {CSR_BASE_ADDR + off, dat, 1'b1, 1'b1};
    endfunction

    // Layer sequencing FSM with registered bus request and status outputs
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state         <= S_IDLE;
            req_q         <= '0;
            cfg_q         <= '0;
            trig_q        <= '0;
            pres_q        <= 1'b0;
            idx           <= '0;
            gap_cnt       <= '0;
            polls         <= '0;
            abort_pend    <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            layers_done_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (desc_valid_i) begin
                        cfg_q      <= desc_cfg_i;
                        trig_q     <= desc_trigger_i;
                        pres_q     <= desc_preserve_ifmap_i;
                        error_o    <= 1'b0;
                        abort_pend <= 1'b0;
                        idx        <= 3'd1;
                        req_q      <= wr_req(32'd1, desc_cfg_i[31:0]);
                        state      <= S_WR_CFG;
                    end
                end
                S_WR_CFG: begin
                    if (accept) begin
                        if (abort_now) begin
                            req_q      <= CLEAR_REQ;
                            abort_pend <= 1'b0;
                            state      <= S_ABORT;
                        end else if (idx == 3'd6) begin
                            req_q <= wr_req(32'd0, {19'b0, pres_q, 8'b0, 1'b0, trig_q});
                            state <= S_TRIGGER;
                        end else begin
                            idx   <= idx + 3'd1;
                            req_q <= wr_req({29'd0, idx} + 32'd1, cfg_q[{idx, 5'd0} +: 32]);
                        end
                    end else begin
                        abort_pend <= abort_now;
                    end
                end
                S_TRIGGER: begin
                    if (accept) begin
                        if (abort_now) begin
                            req_q      <= CLEAR_REQ;
                            abort_pend <= 1'b0;
                            state      <= S_ABORT;
                        end else begin
                            req_q   <= '0;
                            gap_cnt <= 8'(POLL_GAP);
                            polls   <= '0;
                            state   <= S_GAP;
                        end
                    end else begin
                        abort_pend <= abort_now;
                    end
                end
                S_GAP: begin
                    if (abort_now) begin
                        req_q      <= CLEAR_REQ;
                        abort_pend <= 1'b0;
                        state      <= S_ABORT;
                    end else if (gap_cnt <= 8'd1) begin
                        // counter reaching zero issues the poll, giving POLL_GAP idle cycles
                        gap_cnt <= '0;
                        req_q   <= RD_REQ;
                        state   <= S_POLL_REQ;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                S_POLL_REQ: begin
                    abort_pend <= abort_now;
                    if (accept) begin
                        req_q <= '0;
                        state <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (rd_vld) begin
                        if (abort_now) begin
                            req_q      <= CLEAR_REQ;
                            abort_pend <= 1'b0;
                            state      <= S_ABORT;
                        end else if (!rd_busy) begin
                            done_o        <= 1'b1;
                            layers_done_o <= layers_done_o + 16'd1;
                            state         <= S_DONE;
                        end else if (polls == TIMEOUT_POLLS - 16'd1) begin
                            error_o <= 1'b1;
                            req_q   <= CLEAR_REQ;
                            state   <= S_ERR;
                        end else begin
                            polls   <= polls + 16'd1;
                            gap_cnt <= 8'(POLL_GAP);
                            state   <= S_GAP;
                        end
                    end else begin
                        abort_pend <= abort_now;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_ERR, S_ABORT: begin
                    if (accept) begin
                        req_q <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    req_q <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_layer_sequencer.sv
`timescale 1ns/1ps
// Bench for qracc_layer_sequencer: CSR slave model with stalls and delayed read data,
// expected-transaction scoreboard built from layer rules, table vectors plus corner sequences.
module tb_qracc_layer_sequencer;

    localparam logic [31:0] BASE = 32'h0000_0010;
    localparam int GAP_C = 4;
    localparam int TO_C  = 3;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         desc_valid = 1'b0;
    logic         desc_ready;
    logic [191:0] desc_cfg = '0;
    logic [2:0]   desc_trig = '0;
    logic         desc_pres = 1'b0;
    logic         abort = 1'b0;
    logic [65:0]  bus_req;
    logic         s_ready = 1'b0;
    logic         s_rvld = 1'b0;
    logic [31:0]  s_rdata = '0;
    logic         busy, done, err;
    logic [15:0]  layers;

    qracc_layer_sequencer #(
        .CSR_BASE_ADDR(BASE),
        .POLL_GAP(GAP_C),
        .TIMEOUT_POLLS(16'(TO_C))
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .desc_valid_i(desc_valid),
        .desc_ready_o(desc_ready),
        .desc_cfg_i(desc_cfg),
        .desc_trigger_i(desc_trig),
        .desc_preserve_ifmap_i(desc_pres),
        .abort_i(abort),
        .bus_req_o(bus_req),
        .bus_resp_i({s_ready, s_rdata, s_rvld}),
        .busy_o(busy),
        .done_o(done),
        .error_o(err),
        .layers_done_o(layers)
    );

    always #5 clk = ~clk;

    wire [31:0] q_addr = bus_req[65:34];
    wire        q_wen  = bus_req[1];
    wire        q_vld  = bus_req[0];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wen;
    } txn_t;
    txn_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int model_layers = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CSR slave model state
    int          rdy_pct = 100;
    int          resp_lo = 0;
    int          resp_hi = 0;
    int          busy_left = 0;
    int          stall_left = 0;
    logic [31:0] stall_addr = 32'h13;
    int          rd_hs_cnt = 0;
    int          a_cycles = 0;
    int          done_cnt = 0;
    time         last_done_t = 0;
    time         acc_after_done = 0;
    bit          trig_seen = 1'b0;
    bit          rd_out = 1'b0;
    int          resp_cnt = 0;
    logic [65:0] prev_req = '0;
    logic        prev_rdy = 1'b0;

    // Slave: logs handshakes from the previous edge, returns delayed read data, picks ready
    always @(negedge clk) begin
        txn_t e;
        if (!nrst) begin
            rd_out   = 1'b0;
            resp_cnt = 0;
            s_rvld   = 1'b0;
            s_ready  = 1'b0;
            prev_req = '0;
            prev_rdy = 1'b0;
        end else begin
            if (prev_req[0] && prev_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_txn: got addr 0x%0h wen %0b, expected no transaction", prev_req[65:34], prev_req[1]);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_addr", prev_req[65:34], e.addr);
                    check("txn_wen", prev_req[1], e.wen);
                    if (e.wen) check("txn_data", prev_req[33:2], e.data);
                end
                if (!prev_req[1]) begin
                    rd_out = 1'b1;
                    rd_hs_cnt++;
                    resp_cnt = int'($urandom_range(resp_hi, resp_lo));
                end else if (prev_req[65:34] == BASE && prev_req[33:2] != 32'h8) begin
                    trig_seen = 1'b1;
                end
            end else if (prev_req[0]) begin
                check("req_held", bus_req, prev_req);
            end
            if (rd_out) check("one_outstanding", q_vld, 1'b0);
            s_rvld  = 1'b0;
            s_rdata = $urandom;
            if (rd_out) begin
                if (resp_cnt == 0) begin
                    s_rvld  = 1'b1;
                    s_rdata = ($urandom & ~32'h10) | ((busy_left > 0) ? 32'h10 : 32'h0);
                    if (busy_left > 0) busy_left--;
                    rd_out = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
            if (done) begin
                done_cnt++;
                last_done_t = $time;
                check("ready_low_in_done", desc_ready, 1'b0);
            end
            if (q_vld && q_wen && q_addr == stall_addr) a_cycles++;
            if (q_vld && stall_left > 0 && q_addr == stall_addr) begin
                s_ready = 1'b0;
                stall_left--;
            end else begin
                s_ready = (int'($urandom_range(99, 0)) < rdy_pct);
            end
            prev_req = bus_req;
            prev_rdy = s_ready;
        end
    end

    // Expected bus traffic: six config writes then the trigger write
    task automatic push_prefix(input logic [191:0] cfg, input logic [2:0] trig, input logic pres);
        for (int i = 0; i < 6; i++)
            exp_q.push_back({BASE + 32'(i + 1), cfg[32*i +: 32], 1'b1});
        exp_q.push_back({BASE, (32'(pres) << 12) | 32'(trig), 1'b1});
    endtask

    // Full layer: reads until not busy or the poll limit, then a clear write on timeout
    task automatic push_layer(input logic [191:0] cfg, input logic [2:0] trig, input logic pres,
                              input int nbusy, output bit terr);
        int nreads;
        push_prefix(cfg, trig, pres);
        terr   = (nbusy >= TO_C);
        nreads = terr ? TO_C : nbusy + 1;
        for (int i = 0; i < nreads; i++) exp_q.push_back({BASE, 32'h0, 1'b0});
        if (terr) exp_q.push_back({BASE, 32'h8, 1'b1});
    endtask

    task automatic send_desc(input logic [191:0] cfg, input logic [2:0] trig, input logic pres,
                             input int nbusy, input bit hold);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        desc_cfg   = cfg;
        desc_trig  = trig;
        desc_pres  = pres;
        desc_valid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            if (desc_ready) begin
                busy_left      = nbusy;
                acc_after_done = $time - last_done_t;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL desc_accept: ready never seen, expected accept within 1000 cycles");
        end else begin
            @(posedge clk);
        end
        if (!hold) begin
            @(negedge clk);
            desc_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", ok, 1'b1);
        @(negedge clk);
    endtask

    task automatic run_layer(input logic [191:0] cfg, input logic [2:0] trig, input logic pres,
                             input int nbusy, output int meas_reads, output bit meas_err);
        int d0, r0;
        bit terr;
        push_layer(cfg, trig, pres, nbusy, terr);
        d0 = done_cnt;
        r0 = rd_hs_cnt;
        send_desc(cfg, trig, pres, nbusy, 1'b0);
        check("err_clr_on_accept", err, 1'b0);
        wait_idle();
        if (!terr) model_layers++;
        check("done_pulses", done_cnt - d0, terr ? 1'b0 : 1'b1);
        check("error_flag", err, terr);
        check("layers_done", layers, 16'(model_layers));
        check("exp_q_drained", exp_q.size(), 0);
        meas_reads = rd_hs_cnt - r0;
        meas_err   = err;
    endtask

    typedef struct {
        logic [191:0] cfg;
        logic [2:0]   trig;
        logic         pres;
        int           nbusy;
        int           exp_reads;
        bit           exp_err;
    } vec_t;
    vec_t vt[6];

    initial begin
        logic [191:0] cfg_a;
        int  mr, d0, r0;
        bit  me, ok;
        cfg_a = {32'hA6A6_0006, 32'h5555_0005, 32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1133_2201};
        vt[0] = '{cfg_a, 3'd1, 1'b0, 1, 2, 1'b0};
        vt[1] = '{~cfg_a, 3'd5, 1'b1, 0, 1, 1'b0};
        vt[2] = '{cfg_a, 3'd2, 1'b1, 2, 3, 1'b0};
        vt[3] = '{cfg_a, 3'd3, 1'b0, 3, 3, 1'b1};
        vt[4] = '{~cfg_a, 3'd7, 1'b0, 7, 3, 1'b1};
        vt[5] = '{cfg_a, 3'd2, 1'b0, 0, 1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req", bus_req, 66'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_desc_ready", desc_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_error", err, 1'b0);
        check("rst_layers", layers, 16'h0);
        nrst = 1'b1;

        // table vectors, including the timeout pair and the error-clearing descriptor
        for (int i = 0; i < 6; i++) begin
            run_layer(vt[i].cfg, vt[i].trig, vt[i].pres, vt[i].nbusy, mr, me);
            check($sformatf("vec%0d_reads", i), mr, vt[i].exp_reads);
            check($sformatf("vec%0d_err", i), me, vt[i].exp_err);
        end

        // slave holds ready low for 5 cycles on the reg 3 write
        stall_addr = BASE + 32'd3;
        stall_left = 5;
        a_cycles   = 0;
        run_layer(cfg_a, 3'd4, 1'b0, 0, mr, me);
        check("stall_hold_cycles", a_cycles, 6);

        // abort during the post-trigger gap
        push_prefix(cfg_a, 3'd1, 1'b0);
        exp_q.push_back({BASE, 32'h8, 1'b1});
        trig_seen = 1'b0;
        d0 = done_cnt;
        r0 = rd_hs_cnt;
        send_desc(cfg_a, 3'd1, 1'b0, 100, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (trig_seen) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("gap_trigger_seen", ok, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle();
        check("gap_abort_no_done", done_cnt - d0, 0);
        check("gap_abort_no_reads", rd_hs_cnt - r0, 0);
        check("gap_abort_drained", exp_q.size(), 0);
        check("gap_abort_layers", layers, 16'(model_layers));
        check("gap_abort_err", err, 1'b0);

        // abort while a read response is outstanding
        resp_lo = 5;
        resp_hi = 5;
        push_prefix(~cfg_a, 3'd6, 1'b1);
        exp_q.push_back({BASE, 32'h0, 1'b0});
        exp_q.push_back({BASE, 32'h8, 1'b1});
        d0 = done_cnt;
        r0 = rd_hs_cnt;
        send_desc(~cfg_a, 3'd6, 1'b1, 0, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (rd_hs_cnt == r0 + 1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("pw_read_seen", ok, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle();
        resp_lo = 0;
        resp_hi = 0;
        check("pw_abort_no_done", done_cnt - d0, 0);
        check("pw_abort_one_read", rd_hs_cnt - r0, 1);
        check("pw_abort_drained", exp_q.size(), 0);
        check("pw_abort_layers", layers, 16'(model_layers));

        // reset while stuck on the reg 3 write
        stall_addr = BASE + 32'd3;
        stall_left = 50;
        push_prefix(cfg_a, 3'd1, 1'b0);
        send_desc(cfg_a, 3'd1, 1'b0, 0, 1'b0);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (q_vld && q_addr == BASE + 32'd3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("mid_cfg_reached", ok, 1'b1);
        nrst = 1'b0;
        @(negedge clk);
        check("mid_rst_bus_req", bus_req, 66'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_desc_ready", desc_ready, 1'b1);
        check("mid_rst_layers", layers, 16'h0);
        check("mid_rst_error", err, 1'b0);
        exp_q.delete();
        model_layers = 0;
        stall_left   = 0;
        nrst = 1'b1;
        run_layer(cfg_a, 3'd1, 1'b0, 1, mr, me);
        check("post_rst_reads", mr, 2);

        // back-to-back descriptors with valid held high
        push_layer(cfg_a, 3'd1, 1'b0, 0, me);
        push_layer(~cfg_a, 3'd2, 1'b1, 0, me);
        d0 = done_cnt;
        send_desc(cfg_a, 3'd1, 1'b0, 0, 1'b1);
        send_desc(~cfg_a, 3'd2, 1'b1, 0, 1'b0);
        check("b2b_accept_after_done", acc_after_done, 10);
        wait_idle();
        model_layers += 2;
        check("b2b_done_pulses", done_cnt - d0, 2);
        check("b2b_layers", layers, 16'(model_layers));
        check("b2b_drained", exp_q.size(), 0);

        // randomized layers against the scoreboard
        for (int n = 0; n < 20; n++) begin
            rdy_pct = int'($urandom_range(100, 30));
            resp_hi = int'($urandom_range(3, 0));
            run_layer({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                      3'($urandom), 1'($urandom), int'($urandom_range(4, 0)), mr, me);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
